mux_4x1_rr_arbiter: RTL and testbench
=====================================

Name: mux_4x1_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 N-bit mux datapath between four requesters.
- Owns the 2-bit select and a registered output word.
- Grants one requester at a time, holds the grant until that requester releases, then rotates priority.
- Sits between four producer blocks and a single shared consumer bus.

Parameters:
- N, 3, data width of each input word and of f
- HOLD_MAX, 8, max consecutive GRANT cycles per grant; used only when ARB_TIMEOUT_EN is defined; legal range 2..255

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  4  request per requester; req[i] belongs to wi
- w0, w1, w2, w3  input  N  data word from each requester
- gnt  output  4  one-hot grant, registered
- s  output  2  registered mux select, index of the current or last grantee
- f  output  N  registered selected data word
- busy  output  1  high while in GRANT

Behaviour:
- Reset (sync, on clk edge with reset=1):
  - state=IDLE, gnt=4'b0000, s=2'b00, f=0, busy=0.
  - Priority pointer ptr=0, so requester 0 has highest priority.
  - Reset overrides everything, including an active grant.
- State IDLE:
  - No req: stay in IDLE; gnt=0, busy=0; s and f keep their last values.
  - Any req high: winner = first i with req[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4, 2-bit wrap 3->0).
  - Next edge: state=GRANT, gnt=one-hot(winner), s=winner, busy=1, f=w[winner].
- State GRANT, each edge:
  - If req[s]=1: stay in GRANT, f <= w[s] (tracks the grantee's data with 1-cycle latency), gnt and s unchanged.
  - If req[s]=0: release. state=IDLE, gnt=0, busy=0, ptr=s+1 (mod 4); f and s hold their last values.
  - Other requesters' req changes are ignored while in GRANT.
- Latency:
  - req rise to gnt: 1 cycle from IDLE.
  - req fall to gnt=0: 1 cycle.
  - A release costs exactly one IDLE cycle before the next grant (no back-to-back grant).
- Invariants:
  - gnt is zero or one-hot.
  - When gnt!=0, gnt[s]=1.
  - busy equals (gnt!=0).
- Simultaneous requests: resolved only by ptr order; no fixed priority after reset.
- A requester that drops and re-raises req in the same cycle as its release competes normally in the next IDLE cycle, after the ptr has moved past it.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A hold counter is cleared on entry to GRANT and increments every GRANT cycle.
  - When the counter reaches HOLD_MAX-1 with req[s] still high, the next edge performs a forced release: same effect as a normal release (state=IDLE, gnt=0, ptr=s+1).
  - A grant therefore lasts at most HOLD_MAX cycles.
  - The counter resets on reset and is not visible at ports.
- Not defined: no counter is built; a grant lasts until the grantee drops req.
- Port list is identical in both builds.

Test Plan:
- Reset: reset=1 for 2 cycles with req=4'b1111 -> gnt=0, s=0, f=0, busy=0. First edge after reset deasserts -> gnt=4'b0001, s=0.
- Single requester: req=4'b0100, w2=3'b101 -> next edge gnt=4'b0100, s=2, busy=1, f=3'b101. Change w2 to 3'b011 -> f=3'b011 one cycle later. Drop req[2] -> gnt=0, busy=0 next edge, f holds 3'b011.
- Round-robin rotation: req=4'b1111 held; each grantee drops req for 1 cycle after 3 GRANT cycles, then re-raises -> grant order 0,1,2,3,0, with one IDLE cycle between grants.
- Pointer wrap: grant 3 released (ptr=0), then req=4'b1010 -> gnt=4'b0010. After its release (ptr=2), req=4'b1010 -> gnt=4'b1000.
- Mid-grant reset: grant on requester 1 active, reset=1 for one cycle -> gnt=0, busy=0, s=0, f=0 after that edge. With req=4'b0011 afterwards -> gnt=4'b0001 (ptr reset to 0).
- ARB_TIMEOUT_EN, HOLD_MAX=8: req=4'b0011 held constantly -> gnt=4'b0001 for exactly 8 cycles, 1 IDLE cycle, then gnt=4'b0010 for 8 cycles, then back to 4'b0001. Without the macro -> gnt=4'b0001 indefinitely.

Source files
------------

// File: rtl/mux_4x1_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux_4x1_rr_arbiter
//
// Purpose:
//   Round-robin arbiter that shares one 4:1 N-bit mux between four
//   requesters. A grant is held until the grantee drops its request. Priority
//   then rotates to the requester after the one just served. Every release
//   costs exactly one IDLE cycle before the next grant.
//
// Optional build macro:
//   ARB_TIMEOUT_EN - when defined, a grant is forcibly released after
//                    HOLD_MAX consecutive GRANT cycles, even if the grantee
//                    still requests. When undefined, no hold counter exists.
//
// Ports:
//   clk_i    - rising-edge clock
//   reset_i  - synchronous, active-high reset
//   req_i    - request per requester; req_i[i] belongs to wi_i
//   w0_i..w3_i - N-bit data word from each requester
//   gnt_o    - one-hot grant (registered), zero when idle
//   s_o      - registered mux select, index of current/last grantee
//   f_o      - registered selected data word
//   busy_o   - high while a grant is active
// ---------------------------------------------------------------------------
module mux_4x1_rr_arbiter #(
  parameter int N        = 3,
  parameter int HOLD_MAX = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [3:0]   req_i,
  input  logic [N-1:0] w0_i,
  input  logic [N-1:0] w1_i,
  input  logic [N-1:0] w2_i,
  input  logic [N-1:0] w3_i,
  output logic [3:0]   gnt_o,
  output logic [1:0]   s_o,
  output logic [N-1:0] f_o,
  output logic         busy_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arbState_e;

  arbState_e    state_q;
  logic [3:0]   gnt_q;
  logic [1:0]   s_q;
  logic [N-1:0] f_q;
  logic         busy_q;
  logic [1:0]   ptr_q;

  logic [N-1:0] words [4];
  logic [1:0]   winner_d;
  logic         anyReq;
  logic         holdExpired;

  assign words[0] = w0_i;
  assign words[1] = w1_i;
  assign words[2] = w2_i;
  assign words[3] = w3_i;

  assign anyReq = |req_i;

  // Scan ptr, ptr+1, ptr+2, ptr+3 with 2-bit wrap; the first requester
  // found wins. The 2-bit add wraps 3->0 naturally.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    winner_d = 2'd0;
    found    = 1'b0;
    idx      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req_i[idx]) begin
        found    = 1'b1;
        winner_d = idx;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Counts GRANT cycles of the current grant. It is cleared on entry to
  // GRANT, so the value HOLD_MAX-1 marks the last allowed GRANT cycle.
  logic [7:0] holdCnt_q;

  assign holdExpired = (holdCnt_q == 8'(HOLD_MAX - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      holdCnt_q <= 8'd0;
    end else if (state_q == IDLE) begin
      holdCnt_q <= 8'd0;
    end else if (!holdExpired) begin
      holdCnt_q <= holdCnt_q + 8'd1;
    end
  end
`else
  assign holdExpired = 1'b0;
`endif

  // Arbiter FSM with registered outputs. In GRANT only the grantee's own
  // request matters. Releasing moves the pointer just past the grantee, so
  // it gets lowest priority in the following IDLE cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      s_q     <= 2'd0;
      f_q     <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyReq) begin
            state_q <= GRANT;
            gnt_q   <= 4'b0001 << winner_d;
            s_q     <= winner_d;
            f_q     <= words[winner_d];
            busy_q  <= 1'b1;
          end else begin
            gnt_q  <= 4'b0000;
            busy_q <= 1'b0;
          end
        end
        GRANT: begin
          if (req_i[s_q] && !holdExpired) begin
            f_q <= words[s_q];
          end else begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            busy_q  <= 1'b0;
            ptr_q   <= s_q + 2'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 4'b0000;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o  = gnt_q;
  assign s_o    = s_q;
  assign f_o    = f_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_mux_4x1_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_4x1_rr_arbiter
//
// Directed testbench for mux_4x1_rr_arbiter (N=3, HOLD_MAX=8). It covers
// reset, single-requester grants, data tracking, round-robin rotation,
// pointer wrap, mid-grant reset and long holds. Each expected value is
// written by hand from the arbiter's intended behaviour.
// ---------------------------------------------------------------------------
module tb_mux_4x1_rr_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [2:0] w0, w1, w2, w3;
  logic [3:0] gnt;
  logic [1:0] s;
  logic [2:0] f;
  logic       busy;

  int testCount = 0;
  int failCount = 0;

  mux_4x1_rr_arbiter #(
    .N        (3),
    .HOLD_MAX (8)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .req_i   (req),
    .w0_i    (w0),
    .w1_i    (w1),
    .w2_i    (w2),
    .w3_i    (w3),
    .gnt_o   (gnt),
    .s_o     (s),
    .f_o     (f),
    .busy_o  (busy)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling outputs
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Compare every output against hand-computed values
  task automatic checkOutput(input string tag, input logic [3:0] expGnt,
                             input logic [1:0] expS, input logic [2:0] expF,
                             input logic expBusy);
    testCount++;
    assert (gnt === expGnt) else begin
      failCount++;
      $error("[TB] FAIL %s gnt: got %b expected %b", tag, gnt, expGnt);
    end
    testCount++;
    assert (s === expS) else begin
      failCount++;
      $error("[TB] FAIL %s s: got %0d expected %0d", tag, s, expS);
    end
    testCount++;
    assert (f === expF) else begin
      failCount++;
      $error("[TB] FAIL %s f: got %b expected %b", tag, f, expF);
    end
    testCount++;
    assert (busy === expBusy) else begin
      failCount++;
      $error("[TB] FAIL %s busy: got %b expected %b", tag, busy, expBusy);
    end
  endtask

  // Directed sequence
  initial begin
    logic [2:0] wv [4];
    logic [1:0] g;

    wv[0] = 3'b001;
    wv[1] = 3'b010;
    wv[2] = 3'b101;
    wv[3] = 3'b110;
    w0 = wv[0]; w1 = wv[1]; w2 = wv[2]; w3 = wv[3];

    // Reset held for 2 edges with all requests high
    reset = 1'b1;
    req   = 4'b1111;
    applyStimulus();
    applyStimulus();
    checkOutput("reset", 4'b0000, 2'd0, 3'b000, 1'b0);

    // First edge after reset: ptr=0, so requester 0 wins
    reset = 1'b0;
    applyStimulus();
    checkOutput("postReset", 4'b0001, 2'd0, 3'b001, 1'b1);

    // Release requester 0, which moves ptr to 1
    req = 4'b0000;
    applyStimulus();
    checkOutput("release0", 4'b0000, 2'd0, 3'b001, 1'b0);

    // Single requester 2 with data tracking
    req = 4'b0100;
    applyStimulus();
    checkOutput("single2", 4'b0100, 2'd2, 3'b101, 1'b1);
    w2 = 3'b011;
    wv[2] = 3'b011;
    applyStimulus();
    checkOutput("track2", 4'b0100, 2'd2, 3'b011, 1'b1);
    req = 4'b0000;
    applyStimulus();
    checkOutput("release2", 4'b0000, 2'd2, 3'b011, 1'b0);

    // Rotation: ptr=3 now, so the order is 3,0,1,2,3 with one IDLE cycle
    // between grants
    for (int k = 0; k < 5; k++) begin
      g = 2'(3 + k);
      req = 4'b1111;
      applyStimulus();
      checkOutput("rotGrant", 4'b0001 << g, g, wv[g], 1'b1);
      applyStimulus();
      applyStimulus();
      checkOutput("rotHold", 4'b0001 << g, g, wv[g], 1'b1);
      req[g] = 1'b0;
      applyStimulus();
      checkOutput("rotIdle", 4'b0000, g, wv[g], 1'b0);
    end

    // Pointer wrap: ptr=0 after requester 3 released
    req = 4'b1010;
    applyStimulus();
    checkOutput("wrapA", 4'b0010, 2'd1, 3'b010, 1'b1);
    req = 4'b0000;
    applyStimulus();
    checkOutput("wrapArel", 4'b0000, 2'd1, 3'b010, 1'b0);
    req = 4'b1010;
    applyStimulus();
    checkOutput("wrapB", 4'b1000, 2'd3, 3'b110, 1'b1);

    // Other requests are ignored while a grant is active
    req = 4'b1111;
    applyStimulus();
    checkOutput("ignoreOthers", 4'b1000, 2'd3, 3'b110, 1'b1);

    // Mid-grant reset: get a grant on requester 1 first (ptr=0 afterwards)
    req = 4'b0000;
    applyStimulus();
    req = 4'b0010;
    applyStimulus();
    checkOutput("grant1", 4'b0010, 2'd1, 3'b010, 1'b1);
    reset = 1'b1;
    applyStimulus();
    checkOutput("midReset", 4'b0000, 2'd0, 3'b000, 1'b0);
    reset = 1'b0;
    req = 4'b0011;
    applyStimulus();
    checkOutput("afterReset", 4'b0001, 2'd0, 3'b001, 1'b1);

    // Long hold with req=0011 held constantly; grant 0 is in its 1st cycle
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 7; k++) begin
      applyStimulus();
      checkOutput("hold0", 4'b0001, 2'd0, 3'b001, 1'b1);
    end
    applyStimulus();
    checkOutput("timeout0", 4'b0000, 2'd0, 3'b001, 1'b0);
    applyStimulus();
    checkOutput("grantAfterTimeout", 4'b0010, 2'd1, 3'b010, 1'b1);
    for (int k = 0; k < 7; k++) begin
      applyStimulus();
      checkOutput("hold1", 4'b0010, 2'd1, 3'b010, 1'b1);
    end
    applyStimulus();
    checkOutput("timeout1", 4'b0000, 2'd1, 3'b010, 1'b0);
    applyStimulus();
    checkOutput("backTo0", 4'b0001, 2'd0, 3'b001, 1'b1);
`else
    for (int k = 0; k < 15; k++) begin
      applyStimulus();
      checkOutput("holdForever", 4'b0001, 2'd0, 3'b001, 1'b1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
